// File: rtl/infifo_pingpong_asmskip.sv
// Input FIFO for the LDPC decoder front end: strips leading ASM words from each burst and
// spreads payload round-robin over NB lane memories, double-buffered as ping-pong frames.
module infifo_pingpong_asmskip #(
  parameter int W          = 6,
  parameter int SYMS       = 32,
  parameter int NB         = 16,
  parameter int FRAMEWORDS = 256,
  parameter int ASMWORDS   = 1,
  parameter int DEPTH      = FRAMEWORDS / NB,
  parameter int AW         = $clog2(DEPTH),
  parameter int CW         = $clog2(ASMWORDS + FRAMEWORDS + 1),
  localparam int DW        = SYMS * W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [DW-1:0]    wr_din,
  output logic             in_ready,
  output logic             frame_ready,
  output logic             rd_bank,
  output logic             rd_valid_bank,
  input  logic [AW-1:0]    rd_addr,
  input  logic             rd_en,
  output logic [NB*DW-1:0] dout_nb,
  input  logic             rd_done,
  output logic             frame_err,
  output logic             overflow
);

  localparam int LW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [LW-1:0] LANE_LAST = LW'(NB - 1);
  localparam logic [AW-1:0] ADDR_LAST = AW'(DEPTH - 1);
  localparam logic [CW-1:0] ASM_LAST  = CW'(ASMWORDS);

  typedef enum logic [1:0] {S_IDLE, S_ASM, S_WRITE, S_DROP} state_t;

  state_t          state, state_d;
  logic            wr_en_q;
  logic [DW-1:0]   din_q;
  logic [CW-1:0]   cnt, cnt_d;
  logic [LW-1:0]   lane, lane_d;
  logic [AW-1:0]   addr, addr_d;
  logic [1:0]      full, full_d;
  logic            wr_bank;
  logic            wr_do, commit, abort, drop_start, release_buf;

  logic [DW-1:0]   mem [2][NB][DEPTH];

  assign in_ready      = ~full[wr_bank];
  assign rd_valid_bank = full[rd_bank];
  assign release_buf   = rd_done & full[rd_bank];

  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    lane_d     = lane;
    addr_d     = addr;
    wr_do      = 1'b0;
    abort      = 1'b0;
    drop_start = 1'b0;
    case (state)
      S_IDLE: begin
        if (wr_en_q) begin
          cnt_d = CW'(1);
          if (full[wr_bank]) begin
            state_d    = S_DROP;
            drop_start = 1'b1;
          end else if (ASMWORDS > 0) begin
            state_d = S_ASM;
          end else begin
            state_d = S_WRITE;
            wr_do   = 1'b1;
          end
        end
      end
      S_ASM: begin
        if (!wr_en_q) begin
          abort = 1'b1;
        end else begin
          cnt_d = cnt + CW'(1);
          // all marker words consumed: the word in hand is payload 0
          if (cnt == ASM_LAST) begin
            wr_do   = 1'b1;
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        if (!wr_en_q) begin
          abort = 1'b1;
        end else begin
          cnt_d = cnt + CW'(1);
          wr_do = 1'b1;
        end
      end
      S_DROP: begin
        if (!wr_en_q) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    commit = wr_do && (lane == LANE_LAST) && (addr == ADDR_LAST);

    if (wr_do) begin
      if (lane == LANE_LAST) begin
        lane_d = '0;
        addr_d = addr + AW'(1);
      end else begin
        lane_d = lane + LW'(1);
      end
    end

    if (commit || abort) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      lane_d  = '0;
      addr_d  = '0;
    end

    // commit and release never target the same buffer when both are live
    full_d = full;
    if (commit)      full_d[wr_bank] = 1'b1;
    if (release_buf) full_d[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_q     <= 1'b0;
      din_q       <= '0;
      state       <= S_IDLE;
      cnt         <= '0;
      lane        <= '0;
      addr        <= '0;
      full        <= 2'b00;
      wr_bank     <= 1'b0;
      rd_bank     <= 1'b0;
      frame_ready <= 1'b0;
      frame_err   <= 1'b0;
      overflow    <= 1'b0;
      dout_nb     <= '0;
    end else begin
      wr_en_q     <= wr_en;
      din_q       <= wr_din;
      state       <= state_d;
      cnt         <= cnt_d;
      lane        <= lane_d;
      addr        <= addr_d;
      full        <= full_d;
      frame_ready <= commit;
      frame_err   <= abort;
      if (commit)      wr_bank  <= ~wr_bank;
      if (release_buf) rd_bank  <= ~rd_bank;
      if (drop_start)  overflow <= 1'b1;
      if (rd_en) begin
        for (int n = 0; n < NB; n++) begin
          dout_nb[n*DW +: DW] <= mem[rd_bank][n][rd_addr];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_do) mem[wr_bank][lane][addr] <= din_q;
  end

endmodule

// File: tb/tb_infifo_pingpong_asmskip.sv
// Bench for infifo_pingpong_asmskip: default-parameter instance plus a small ASM-less instance.
module tb_infifo_pingpong_asmskip;
  localparam int DW = 192;
  localparam int NB = 16;
  localparam int FW = 256;
  localparam int ASM = 1;
  localparam int DEPTH = FW / NB;
  localparam int NB1 = 8;
  localparam int FW1 = 64;
  localparam int DEPTH1 = FW1 / NB1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              wr_en = 1'b0;
  logic [DW-1:0]     wr_din = '0;
  logic              in_ready, frame_ready, rd_bank, rd_valid_bank, frame_err, overflow;
  logic [3:0]        rd_addr = '0;
  logic              rd_en = 1'b0, rd_done = 1'b0;
  logic [NB*DW-1:0]  dout_nb;

  logic              s_wr_en = 1'b0;
  logic [DW-1:0]     s_wr_din = '0;
  logic              s_in_ready, s_frame_ready, s_rd_bank, s_rd_valid_bank, s_frame_err, s_overflow;
  logic [2:0]        s_rd_addr = '0;
  logic              s_rd_en = 1'b0;
  logic [NB1*DW-1:0] s_dout_nb;

  infifo_pingpong_asmskip dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_din(wr_din), .in_ready(in_ready),
    .frame_ready(frame_ready), .rd_bank(rd_bank), .rd_valid_bank(rd_valid_bank),
    .rd_addr(rd_addr), .rd_en(rd_en), .dout_nb(dout_nb), .rd_done(rd_done),
    .frame_err(frame_err), .overflow(overflow)
  );

  infifo_pingpong_asmskip #(.NB(NB1), .FRAMEWORDS(FW1), .ASMWORDS(0)) dut_s (
    .clk(clk), .rst(rst), .wr_en(s_wr_en), .wr_din(s_wr_din), .in_ready(s_in_ready),
    .frame_ready(s_frame_ready), .rd_bank(s_rd_bank), .rd_valid_bank(s_rd_valid_bank),
    .rd_addr(s_rd_addr), .rd_en(s_rd_en), .dout_nb(s_dout_nb), .rd_done(1'b0),
    .frame_err(s_frame_err), .overflow(s_overflow)
  );

  int total = 0;
  int bad = 0;
  int fr_cnt = 0;
  int err_cnt = 0;
  int s_fr_cnt = 0;
  logic [DW-1:0] payq[$];

  always @(negedge clk) begin
    if (frame_ready === 1'b1) fr_cnt++;
    if (frame_err === 1'b1) err_cnt++;
    if (s_frame_ready === 1'b1) s_fr_cnt++;
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives n consecutive words base..base+n-1; keep pushes the payload words expected in memory.
  task automatic send_burst(input int n, input int base, input bit keep);
    for (int i = 0; i < n; i++) begin
      wr_en  = 1'b1;
      wr_din = DW'(base + i);
      if (keep && i >= ASM && i < ASM + FW) payq.push_back(DW'(base + i));
      tick();
    end
  endtask

  task automatic read_addr(input int a);
    rd_addr = 4'(a);
    rd_en   = 1'b1;
    tick();
    rd_en   = 1'b0;
  endtask

  task automatic check_frame(input string name);
    logic [DW-1:0] exp;
    for (int a = 0; a < DEPTH; a++) begin
      read_addr(a);
      for (int n = 0; n < NB; n++) begin
        total++;
        if (payq.size() == 0) begin
          bad++;
          $display("FAIL %s: scoreboard empty at addr %0d lane %0d", name, a, n);
        end else begin
          exp = payq.pop_front();
          if (dout_nb[n*DW +: DW] !== exp) begin
            bad++;
            $display("FAIL %s: addr %0d lane %0d got %0h want %0h", name, a, n,
                     dout_nb[n*DW +: DW], exp);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    wr_en = 1'b0; s_wr_en = 1'b0; rd_en = 1'b0; rd_done = 1'b0;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    payq.delete();
    total++; if (in_ready !== 1'b1)      begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    total++; if (frame_ready !== 1'b0)   begin bad++; $display("FAIL reset_frame_ready: got %b want 0", frame_ready); end
    total++; if (rd_bank !== 1'b0)       begin bad++; $display("FAIL reset_rd_bank: got %b want 0", rd_bank); end
    total++; if (rd_valid_bank !== 1'b0) begin bad++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid_bank); end
    total++; if (dout_nb !== '0)         begin bad++; $display("FAIL reset_dout: got nonzero want 0"); end
    total++; if (frame_err !== 1'b0)     begin bad++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    total++; if (overflow !== 1'b0)      begin bad++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    total++; if (s_in_ready !== 1'b1)    begin bad++; $display("FAIL reset_s_in_ready: got %b want 1", s_in_ready); end
    tick();
  endtask

  task automatic test_single();
    test_reset();
    fr_cnt = 0; err_cnt = 0;
    send_burst(ASM + FW, 0, 1'b1);
    wr_en = 1'b0;
    tick();
    total++; if (frame_ready !== 1'b1)   begin bad++; $display("FAIL single_fr_timing: got %b want 1", frame_ready); end
    total++; if (rd_valid_bank !== 1'b1) begin bad++; $display("FAIL single_valid_timing: got %b want 1", rd_valid_bank); end
    tick(3);
    total++; if (fr_cnt !== 1)   begin bad++; $display("FAIL single_fr_count: got %0d want 1", fr_cnt); end
    total++; if (err_cnt !== 0)  begin bad++; $display("FAIL single_err_count: got %0d want 0", err_cnt); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL single_in_ready: got %b want 1", in_ready); end
    read_addr(0);
    total++; if (dout_nb[0 +: DW] !== DW'(1)) begin bad++; $display("FAIL single_l0a0: got %0h want 1", dout_nb[0 +: DW]); end
    read_addr(15);
    total++; if (dout_nb[15*DW +: DW] !== DW'(256)) begin bad++; $display("FAIL single_l15a15: got %0h want 100", dout_nb[15*DW +: DW]); end
    check_frame("single_frame");
    rd_done = 1'b1; tick(); rd_done = 1'b0;
    total++; if (rd_valid_bank !== 1'b0) begin bad++; $display("FAIL single_release: got %b want 0", rd_valid_bank); end
    total++; if (rd_bank !== 1'b1)       begin bad++; $display("FAIL single_rd_bank: got %b want 1", rd_bank); end
  endtask

  task automatic test_back_to_back();
    test_reset();
    fr_cnt = 0; err_cnt = 0;
    send_burst(ASM + FW, 0, 1'b1);
    send_burst(ASM + FW, 1000, 1'b1);
    wr_en = 1'b0;
    tick(3);
    total++; if (fr_cnt !== 2)          begin bad++; $display("FAIL pp_fr_count: got %0d want 2", fr_cnt); end
    total++; if (in_ready !== 1'b0)     begin bad++; $display("FAIL pp_in_ready_low: got %b want 0", in_ready); end
    total++; if (overflow !== 1'b0)     begin bad++; $display("FAIL pp_overflow_early: got %b want 0", overflow); end
    fr_cnt = 0;
    send_burst(ASM + FW, 2000, 1'b0);
    wr_en = 1'b0;
    tick(3);
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL pp_overflow: got %b want 1", overflow); end
    total++; if (fr_cnt !== 0)      begin bad++; $display("FAIL pp_drop_fr: got %0d want 0", fr_cnt); end
    total++; if (err_cnt !== 0)     begin bad++; $display("FAIL pp_drop_err: got %0d want 0", err_cnt); end
    check_frame("pp_frame0");
    rd_done = 1'b1; tick(); rd_done = 1'b0;
    total++; if (rd_bank !== 1'b1)       begin bad++; $display("FAIL pp_rd_bank: got %b want 1", rd_bank); end
    total++; if (in_ready !== 1'b1)      begin bad++; $display("FAIL pp_in_ready_high: got %b want 1", in_ready); end
    total++; if (rd_valid_bank !== 1'b1) begin bad++; $display("FAIL pp_valid_b1: got %b want 1", rd_valid_bank); end
    total++; if (overflow !== 1'b1)      begin bad++; $display("FAIL pp_overflow_sticky: got %b want 1", overflow); end
    check_frame("pp_frame1");
  endtask

  task automatic test_abort();
    test_reset();
    fr_cnt = 0; err_cnt = 0;
    send_burst(100, 0, 1'b0);
    wr_en = 1'b0;
    tick(2);
    total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL abort_err_timing: got %b want 1", frame_err); end
    tick(3);
    total++; if (err_cnt !== 1)          begin bad++; $display("FAIL abort_err_count: got %0d want 1", err_cnt); end
    total++; if (fr_cnt !== 0)           begin bad++; $display("FAIL abort_fr_count: got %0d want 0", fr_cnt); end
    total++; if (rd_valid_bank !== 1'b0) begin bad++; $display("FAIL abort_valid: got %b want 0", rd_valid_bank); end
    send_burst(ASM + FW, 500, 1'b1);
    wr_en = 1'b0;
    tick(3);
    total++; if (fr_cnt !== 1)           begin bad++; $display("FAIL abort_next_fr: got %0d want 1", fr_cnt); end
    total++; if (rd_bank !== 1'b0)       begin bad++; $display("FAIL abort_next_bank: got %b want 0", rd_bank); end
    total++; if (rd_valid_bank !== 1'b1) begin bad++; $display("FAIL abort_next_valid: got %b want 1", rd_valid_bank); end
    total++; if (in_ready !== 1'b1)      begin bad++; $display("FAIL abort_next_ready: got %b want 1", in_ready); end
    check_frame("abort_next_frame");
  endtask

  task automatic test_same_edge();
    test_reset();
    send_burst(ASM + FW, 0, 1'b1);
    wr_en = 1'b0;
    tick(3);
    send_burst(ASM + FW, 3000, 1'b1);
    wr_en   = 1'b0;
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
    total++; if (frame_ready !== 1'b1)   begin bad++; $display("FAIL same_fr: got %b want 1", frame_ready); end
    total++; if (rd_bank !== 1'b1)       begin bad++; $display("FAIL same_rd_bank: got %b want 1", rd_bank); end
    total++; if (rd_valid_bank !== 1'b1) begin bad++; $display("FAIL same_full1: got %b want 1", rd_valid_bank); end
    total++; if (in_ready !== 1'b1)      begin bad++; $display("FAIL same_in_ready: got %b want 1", in_ready); end
    for (int i = 0; i < FW; i++) void'(payq.pop_front());
    check_frame("same_frame1");
    rd_done = 1'b1; tick(); rd_done = 1'b0;
    total++; if (rd_valid_bank !== 1'b0) begin bad++; $display("FAIL same_release2: got %b want 0", rd_valid_bank); end
  endtask

  task automatic test_small_noasm();
    logic [DW-1:0] exp;
    test_reset();
    s_fr_cnt = 0;
    for (int i = 0; i < FW1; i++) begin
      s_wr_en  = 1'b1;
      s_wr_din = DW'(i);
      tick();
    end
    s_wr_en = 1'b0;
    tick();
    total++; if (s_frame_ready !== 1'b1) begin bad++; $display("FAIL small_fr_timing: got %b want 1", s_frame_ready); end
    tick(2);
    total++; if (s_fr_cnt !== 1)           begin bad++; $display("FAIL small_fr_count: got %0d want 1", s_fr_cnt); end
    total++; if (s_rd_valid_bank !== 1'b1) begin bad++; $display("FAIL small_valid: got %b want 1", s_rd_valid_bank); end
    for (int a = 0; a < DEPTH1; a++) begin
      s_rd_addr = 3'(a);
      s_rd_en   = 1'b1;
      tick();
      s_rd_en   = 1'b0;
      for (int n = 0; n < NB1; n++) begin
        exp = DW'(a * NB1 + n);
        total++;
        if (s_dout_nb[n*DW +: DW] !== exp) begin
          bad++;
          $display("FAIL small_addr%0d_lane%0d: got %0h want %0h", a, n, s_dout_nb[n*DW +: DW], exp);
        end
      end
      if (a == 2) begin
        total++;
        if (s_dout_nb[3*DW +: DW] !== DW'(19)) begin
          bad++; $display("FAIL small_l3a2: got %0h want 13", s_dout_nb[3*DW +: DW]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    test_reset();
    send_burst(ASM + FW, 0, 1'b0);
    wr_en = 1'b0;
    tick(3);
    total++; if (rd_valid_bank !== 1'b1) begin bad++; $display("FAIL mid_pre_valid: got %b want 1", rd_valid_bank); end
    err_cnt = 0; fr_cnt = 0;
    send_burst(50, 4000, 1'b0);
    test_reset();
    tick(3);
    total++; if (err_cnt !== 0) begin bad++; $display("FAIL mid_no_err: got %0d want 0", err_cnt); end
    total++; if (fr_cnt !== 0)  begin bad++; $display("FAIL mid_no_fr: got %0d want 0", fr_cnt); end
    send_burst(ASM + FW, 5000, 1'b1);
    wr_en = 1'b0;
    tick(3);
    total++; if (fr_cnt !== 1)           begin bad++; $display("FAIL mid_next_fr: got %0d want 1", fr_cnt); end
    total++; if (rd_bank !== 1'b0)       begin bad++; $display("FAIL mid_next_bank: got %b want 0", rd_bank); end
    total++; if (rd_valid_bank !== 1'b1) begin bad++; $display("FAIL mid_next_valid: got %b want 1", rd_valid_bank); end
    total++; if (in_ready !== 1'b1)      begin bad++; $display("FAIL mid_next_ready: got %b want 1", in_ready); end
    check_frame("mid_next_frame");
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_abort();
    test_same_edge();
    test_small_noasm();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
